dcache_ctrl: RTL



---
 rtl/dcache_ctrl_if.sv | 26 ++
 rtl/dcache_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl_if.sv
// CPU MEM-stage and line-memory signal bundle for the L1 data cache controller.
// The controller binds the slave view; whatever drives the CPU and memory binds master.
interface dcache_ctrl_if;
  logic         cpu_req_i;
  logic         cpu_we_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    output cpu_data_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_data_o
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    input  cpu_data_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Load hits return in the request cycle; misses stall the pipeline until the line is refilled.
module dcache_ctrl #(
  parameter int NUM_SETS = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  dcache_ctrl_if.slave bus
);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = 27 - IDX_W;
  localparam int LINE_W = 256;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITEBACK,
    S_ALLOCATE
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_SETS-1:0] valid_q, valid_d;
  logic [NUM_SETS-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]    miss_tag_q, miss_tag_d;
  logic [IDX_W-1:0]    miss_idx_q, miss_idx_d;
  logic                gap_q, gap_d;

  logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
  logic [LINE_W-1:0]   line_mem [NUM_SETS];

  logic [2:0]          word_sel;
  logic [IDX_W-1:0]    req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic [LINE_W-1:0]   req_line;
  logic [31:0]         req_word;
  logic                hit;
  logic                store_en;
  logic                fill_en;
  logic                unused_addr_bits;

  assign word_sel         = bus.cpu_addr_i[4:2];
  assign req_idx          = bus.cpu_addr_i[4+IDX_W:5];
  assign req_tag          = bus.cpu_addr_i[31:5+IDX_W];
  assign unused_addr_bits = ^bus.cpu_addr_i[1:0];

  assign req_line = line_mem[req_idx];
  assign req_word = req_line[word_sel*32 +: 32];
  assign hit      = bus.cpu_req_i & valid_q[req_idx] & (tag_mem[req_idx] == req_tag);

  // Stores only land while idle; during a miss the array belongs to the refill.
  assign store_en = hit & bus.cpu_we_i & (state_q == S_IDLE);
  // The first ALLOCATE cycle after a write-back keeps mem_req_o low, so acks there are ignored.
  assign fill_en  = (state_q == S_ALLOCATE) & ~gap_q & bus.mem_ack_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
      gap_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      miss_tag_q <= miss_tag_d;
      miss_idx_q <= miss_idx_d;
      gap_q      <= gap_d;
    end
  end

  // Tag and data arrays: no reset, contents only meaningful under a valid bit.
  always_ff @(posedge clk_i) begin
    if (fill_en) begin
      line_mem[miss_idx_q] <= bus.mem_data_i;
      tag_mem[miss_idx_q]  <= miss_tag_q;
    end else if (store_en) begin
      line_mem[req_idx][word_sel*32 +: 32] <= bus.cpu_data_i;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    miss_tag_d = miss_tag_q;
    miss_idx_d = miss_idx_q;
    gap_d      = gap_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cpu_req_i & ~hit) begin
          miss_tag_d = req_tag;
          miss_idx_d = req_idx;
          gap_d      = 1'b0;
          state_d    = (valid_q[req_idx] & dirty_q[req_idx]) ? S_WRITEBACK : S_ALLOCATE;
        end
      end
      S_WRITEBACK: begin
        if (bus.mem_ack_i) begin
          gap_d   = 1'b1;
          state_d = S_ALLOCATE;
        end
      end
      S_ALLOCATE: begin
        if (gap_q) begin
          gap_d = 1'b0;
        end else if (bus.mem_ack_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (store_en) begin
      dirty_d[req_idx] = 1'b1;
    end
    if (fill_en) begin
      valid_d[miss_idx_q] = 1'b1;
      dirty_d[miss_idx_q] = 1'b0;
    end
  end

  // Output logic
  always_comb begin
    bus.cpu_stall_o = bus.cpu_req_i & ~((state_q == S_IDLE) & hit);
    bus.cpu_data_o  = (hit & ~bus.cpu_we_i) ? req_word : 32'h0;
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = 32'h0;
    bus.mem_data_o  = '0;

    case (state_q)
      S_WRITEBACK: begin
        bus.mem_req_o  = 1'b1;
        bus.mem_we_o   = 1'b1;
        bus.mem_addr_o = {tag_mem[miss_idx_q], miss_idx_q, 5'b0};
        bus.mem_data_o = line_mem[miss_idx_q];
      end
      S_ALLOCATE: begin
        if (!gap_q) begin
          bus.mem_req_o  = 1'b1;
          bus.mem_addr_o = {miss_tag_q, miss_idx_q, 5'b0};
        end
      end
      default: ;
    endcase
  end
endmodule
